// File: rtl/i2d_if_pkg.sv
// rtl/i2d_if_pkg.sv - shared constants, state encoding and entry type for the i2d fetch stage
// Contents: I2D_NOP, I2D_RESET_PC, fetch FSM state enum, {pc,ins} prefetch entry, word_align().
package i2d_if_pkg;

  localparam logic [31:0] I2D_NOP      = 32'h0000_0000;
  localparam logic [31:0] I2D_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    I2D_IF_ST_IDLE = 2'd0,  // no request outstanding
    I2D_IF_ST_REQ  = 2'd1,  // request outstanding, result kept
    I2D_IF_ST_DROP = 2'd2   // request outstanding, result discarded
  } if_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/i2d_if_if.sv
// rtl/i2d_if_if.sv - instruction memory req/ack bus between fetch stage and memory
// Signals: im_req/im_addr (fetch -> memory), im_ack/im_data (memory -> fetch).
// Modports: master = fetch stage, slave = instruction memory.
interface i2d_if_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_data;

  modport master (output im_req, output im_addr, input im_ack, input im_data);
  modport slave  (input im_req, input im_addr, output im_ack, output im_data);
endinterface

// File: rtl/i2d_if_fifo.sv
// rtl/i2d_if_fifo.sv - synchronous prefetch FIFO with push/pop/flush
// Ports: clk, rst (sync, active-high), flush, push/push_data, pop/head,
//        count, full, empty. Flush takes priority over a same-cycle push.
module i2d_if_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/i2d_if.sv
// rtl/i2d_if.sv - i2d instruction fetch stage: fetch PC, single-outstanding IM reads, prefetch FIFO
// Ports: clk, rst (sync, active-high), id_dis (decode stall), redirect/redirect_pc (flush+refetch),
//        im (i2d_if_if.master: im_req/im_addr/im_ack/im_data), if_ins/if_pc/if_valid/if_err to decode.
// Optional: I2D_IF_ALIGN_CHECK_EN enables misaligned-redirect detection on if_err.
module i2d_if
  import i2d_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = I2D_RESET_PC,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INS    = I2D_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_dis,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  i2d_if_if.master    im,
  output logic [31:0] if_ins,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        if_err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if_state_t     state;
  logic [31:0]   fetch_pc;
  logic [31:0]   target_pc;
  logic          pc_ok;
  logic          space_ok;
  logic          issue;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

`ifdef I2D_IF_ALIGN_CHECK_EN
  // A misaligned target is kept as-is so it can be reported; fetching stalls on it.
  assign target_pc = redirect_pc;
  assign pc_ok     = (fetch_pc[1:0] == 2'b00);
`else
  assign target_pc = word_align(redirect_pc);
  assign pc_ok     = 1'b1;
`endif

  // The outstanding request reserves a slot so its returning word always fits.
  assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, (state != I2D_IF_ST_IDLE)};
  assign space_ok   = (occupancy < (CW + 1)'(FIFO_DEPTH));
  assign issue      = (state == I2D_IF_ST_IDLE) && !redirect && space_ok && pc_ok;
  assign fifo_push  = (state == I2D_IF_ST_REQ) && im.im_ack && !redirect;
  assign fifo_pop   = !redirect && !id_dis && !fifo_empty;
  assign push_entry = '{pc: fetch_pc, ins: im.im_data};

  i2d_if_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= I2D_IF_ST_IDLE;
      fetch_pc   <= RESET_PC;
      im.im_req  <= 1'b0;
      im.im_addr <= RESET_PC;
      if_ins     <= NOP_INS;
      if_pc      <= '0;
      if_valid   <= 1'b0;
`ifdef I2D_IF_ALIGN_CHECK_EN
      if_err     <= 1'b0;
`endif
    end else begin
      case (state)
        I2D_IF_ST_IDLE: begin
          if (issue) begin
            state      <= I2D_IF_ST_REQ;
            im.im_req  <= 1'b1;
            im.im_addr <= fetch_pc;
          end
        end
        I2D_IF_ST_REQ, I2D_IF_ST_DROP: begin
          // Request stays up until ack even when redirected; the word is then discarded.
          if (im.im_ack) begin
            state     <= I2D_IF_ST_IDLE;
            im.im_req <= 1'b0;
          end else if (redirect) begin
            state <= I2D_IF_ST_DROP;
          end
        end
        default: begin
          state     <= I2D_IF_ST_IDLE;
          im.im_req <= 1'b0;
        end
      endcase

      if (redirect)       fetch_pc <= target_pc;
      else if (fifo_push) fetch_pc <= fetch_pc + 32'd4;

      if (redirect) begin
        if_ins   <= NOP_INS;
        if_valid <= 1'b0;
`ifdef I2D_IF_ALIGN_CHECK_EN
        if_err   <= 1'b0;
`endif
      end else if (!id_dis) begin
        if (!fifo_empty) begin
          if_ins   <= head.ins;
          if_pc    <= head.pc;
          if_valid <= 1'b1;
        end else begin
          if_ins   <= NOP_INS;
          if_valid <= 1'b0;
`ifdef I2D_IF_ALIGN_CHECK_EN
          if (!pc_ok) begin
            if_pc  <= fetch_pc;
            if_err <= 1'b1;
          end
`endif
        end
      end
    end
  end

`ifndef I2D_IF_ALIGN_CHECK_EN
  assign if_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_push && fifo_full && !fifo_pop));
    end
  end
endmodule
